tim_rr_sel_arbiter: RTL and testbench

TIM_RR_SEL_ARBITER -- requirements
Module: tim_rr_sel_arbiter

---
 rtl/tim_rr_sel_arbiter.sv | 150 +++++++++++++++
 tb/tb_tim_rr_sel_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tim_rr_sel_arbiter.sv
// Three-way round-robin arbiter feeding a one-word output register.
// Define TIM_RR_SEL_ARBITER_GRANT_CNT_EN to add saturating per-requester grant counters.
module tim_rr_sel_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req_valid,
    output logic [2:0]        req_ready,
    input  logic [DATA_W-1:0] req_data_a,
    input  logic [DATA_W-1:0] req_data_b,
    input  logic [DATA_W-1:0] req_data_c,
    output logic [1:0]        sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_src
`ifdef TIM_RR_SEL_ARBITER_GRANT_CNT_EN
    ,
    output logic [7:0]        gnt_cnt_a,
    output logic [7:0]        gnt_cnt_b,
    output logic [7:0]        gnt_cnt_c
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_C    = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    state_t            state;
    logic [1:0]        lg;
    logic [1:0]        cand0;
    logic [1:0]        cand1;
    logic [1:0]        cand2;
    logic              accept;
    logic              xfer;
    logic [DATA_W-1:0] sel_data;

    // Search order lg+1, lg+2, lg (mod 3); lg never holds 3.
    always_comb begin
        cand0 = SEL_A;
        cand1 = SEL_B;
        cand2 = SEL_C;
        unique case (lg)
            2'd0: begin
                cand0 = SEL_B;
                cand1 = SEL_C;
                cand2 = SEL_A;
            end
            2'd1: begin
                cand0 = SEL_C;
                cand1 = SEL_A;
                cand2 = SEL_B;
            end
            default: begin
                cand0 = SEL_A;
                cand1 = SEL_B;
                cand2 = SEL_C;
            end
        endcase
    end

    always_comb begin
        sel = SEL_NONE;
        if (req_valid[cand2]) sel = cand2;
        if (req_valid[cand1]) sel = cand1;
        if (req_valid[cand0]) sel = cand0;
    end

    always_comb begin
        sel_data = '0;
        unique case (sel)
            SEL_A:   sel_data = req_data_a;
            SEL_B:   sel_data = req_data_b;
            SEL_C:   sel_data = req_data_c;
            default: sel_data = '0;
        endcase
    end

    assign accept = !rst && ((state == EMPTY) || out_ready);

    always_comb begin
        req_ready = 3'b000;
        if (accept) begin
            unique case (sel)
                SEL_A:   req_ready = 3'b001;
                SEL_B:   req_ready = 3'b010;
                SEL_C:   req_ready = 3'b100;
                default: req_ready = 3'b000;
            endcase
        end
    end

    assign xfer = |(req_valid & req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= SEL_NONE;
            lg        <= 2'd2;
        end else begin
            if (xfer) begin
                out_data <= sel_data;
                out_src  <= sel;
                lg       <= sel;
            end
            unique case (state)
                EMPTY: begin
                    if (xfer) begin
                        state     <= FULL;
                        out_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (out_ready && !xfer) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef TIM_RR_SEL_ARBITER_GRANT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_cnt_a <= 8'h00;
            gnt_cnt_b <= 8'h00;
            gnt_cnt_c <= 8'h00;
        end else if (xfer) begin
            if (sel == SEL_A && gnt_cnt_a != 8'hFF) gnt_cnt_a <= gnt_cnt_a + 8'h01;
            if (sel == SEL_B && gnt_cnt_b != 8'hFF) gnt_cnt_b <= gnt_cnt_b + 8'h01;
            if (sel == SEL_C && gnt_cnt_c != 8'hFF) gnt_cnt_c <= gnt_cnt_c + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_tim_rr_sel_arbiter.sv
// Directed self-checking bench for tim_rr_sel_arbiter.
// Inputs change on the falling edge; outputs are checked there too.
module tb_tim_rr_sel_arbiter;

    logic       clk;
    logic       rst;
    logic [2:0] req_valid;
    logic [2:0] req_ready;
    logic [7:0] req_data_a;
    logic [7:0] req_data_b;
    logic [7:0] req_data_c;
    logic [1:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_src;
`ifdef TIM_RR_SEL_ARBITER_GRANT_CNT_EN
    logic [7:0] gnt_cnt_a;
    logic [7:0] gnt_cnt_b;
    logic [7:0] gnt_cnt_c;
`endif

    int n_pass;
    int n_total;

    tim_rr_sel_arbiter #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data_a (req_data_a),
        .req_data_b (req_data_b),
        .req_data_c (req_data_c),
        .sel        (sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src)
`ifdef TIM_RR_SEL_ARBITER_GRANT_CNT_EN
        ,
        .gnt_cnt_a  (gnt_cnt_a),
        .gnt_cnt_b  (gnt_cnt_b),
        .gnt_cnt_c  (gnt_cnt_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 3'b111;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
        else n_pass++;
        n_total++;
        if (out_src !== 2'b11) $display("FAIL reset_out_src got %b want 11", out_src);
        else n_pass++;
        n_total++;
        if (req_ready !== 3'b000) $display("FAIL reset_req_ready got %b want 000", req_ready);
        else n_pass++;
        n_total++;
        if (out_data !== 8'h00) $display("FAIL reset_out_data got %h want 00", out_data);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (sel !== 2'b00) $display("FAIL reset_first_sel got %b want 00", sel);
        else n_pass++;
        n_total++;
        if (req_ready !== 3'b001) $display("FAIL reset_first_ready got %b want 001", req_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b1 || out_src !== 2'b00 || out_data !== 8'h11)
            $display("FAIL reset_first_xfer got v=%b src=%b d=%h want v=1 src=00 d=11",
                     out_valid, out_src, out_data);
        else n_pass++;
    endtask

    task automatic test_rotation();
        logic [7:0] exp_d [6];
        logic [1:0] exp_s [6];
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33};
        exp_s = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10};
        req_valid = 3'b111;
        out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_total++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_src !== exp_s[i])
                $display("FAIL rotation_%0d got v=%b d=%h src=%b want v=1 d=%h src=%b",
                         i, out_valid, out_data, out_src, exp_d[i], exp_s[i]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        req_valid  = 3'b001;
        req_data_a = 8'hAA;
        out_ready  = 1'b0;
        do_reset();
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 8'hAA)
            $display("FAIL bp_load got v=%b d=%h want v=1 d=aa", out_valid, out_data);
        else n_pass++;
        req_data_a = 8'hAB;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++;
            if (req_ready !== 3'b000 || out_data !== 8'hAA || out_valid !== 1'b1)
                $display("FAIL bp_hold_%0d got rdy=%b d=%h v=%b want rdy=000 d=aa v=1",
                         i, req_ready, out_data, out_valid);
            else n_pass++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_total++;
        if (req_ready !== 3'b001) $display("FAIL bp_release_ready got %b want 001", req_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b1 || out_data !== 8'hAB)
            $display("FAIL bp_release_data got v=%b d=%h want v=1 d=ab", out_valid, out_data);
        else n_pass++;
    endtask

    task automatic test_idle();
        req_valid = 3'b000;
        out_ready = 1'b1;
        #1;
        n_total++;
        if (sel !== 2'b11 || req_ready !== 3'b000)
            $display("FAIL idle_sel got sel=%b rdy=%b want sel=11 rdy=000", sel, req_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0 || out_data !== 8'hAB || out_src !== 2'b00)
            $display("FAIL idle_drain got v=%b d=%h src=%b want v=0 d=ab src=00",
                     out_valid, out_data, out_src);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL idle_stay got v=%b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_skip();
        req_data_a = 8'h11;
        req_valid  = 3'b001;
        out_ready  = 1'b1;
        do_reset();
        @(negedge clk);
        req_valid = 3'b101;
        #1;
        n_total++;
        if (sel !== 2'b10) $display("FAIL skip_sel_c got %b want 10", sel);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (out_src !== 2'b10 || out_data !== 8'h33)
            $display("FAIL skip_xfer_c got src=%b d=%h want src=10 d=33", out_src, out_data);
        else n_pass++;
        #1;
        n_total++;
        if (sel !== 2'b00) $display("FAIL skip_sel_a got %b want 00", sel);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (out_src !== 2'b00 || out_data !== 8'h11)
            $display("FAIL skip_xfer_a got src=%b d=%h want src=00 d=11", out_src, out_data);
        else n_pass++;
    endtask

    task automatic test_drop();
        // lg = A here; hold the register full so nothing transfers.
        out_ready = 1'b0;
        req_valid = 3'b011;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (sel !== 2'b01 || req_ready !== 3'b000)
            $display("FAIL drop_hold got sel=%b rdy=%b want sel=01 rdy=000", sel, req_ready);
        else n_pass++;
        req_valid = 3'b001;
        #1;
        n_total++;
        if (sel !== 2'b00) $display("FAIL drop_regrant got %b want 00", sel);
        else n_pass++;
        req_valid = 3'b100;
        out_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (out_src !== 2'b10 || out_data !== 8'h33)
            $display("FAIL drop_xfer got src=%b d=%h want src=10 d=33", out_src, out_data);
        else n_pass++;
    endtask

    task automatic test_reset_discard();
        req_valid = 3'b010;
        out_ready = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || out_src !== 2'b11 || out_data !== 8'h00)
            $display("FAIL discard_async got v=%b src=%b d=%h want v=0 src=11 d=00",
                     out_valid, out_src, out_data);
        else n_pass++;
        @(negedge clk);
        req_valid = 3'b111;
        out_ready = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b1 || out_src !== 2'b00)
            $display("FAIL discard_first got v=%b src=%b want v=1 src=00", out_valid, out_src);
        else n_pass++;
    endtask

`ifdef TIM_RR_SEL_ARBITER_GRANT_CNT_EN
    task automatic test_counter();
        req_valid = 3'b000;
        out_ready = 1'b1;
        do_reset();
        n_total++;
        if (gnt_cnt_a !== 8'h00 || gnt_cnt_b !== 8'h00 || gnt_cnt_c !== 8'h00)
            $display("FAIL cnt_reset got a=%h b=%h c=%h want 00", gnt_cnt_a, gnt_cnt_b, gnt_cnt_c);
        else n_pass++;
        req_valid = 3'b010;
        for (int i = 0; i < 300; i++) @(negedge clk);
        n_total++;
        if (gnt_cnt_b !== 8'hFF || gnt_cnt_a !== 8'h00 || gnt_cnt_c !== 8'h00)
            $display("FAIL cnt_sat got a=%h b=%h c=%h want a=00 b=ff c=00",
                     gnt_cnt_a, gnt_cnt_b, gnt_cnt_c);
        else n_pass++;
    endtask
`endif

    initial begin
        n_pass     = 0;
        n_total    = 0;
        rst        = 1'b1;
        req_valid  = 3'b000;
        out_ready  = 1'b0;
        req_data_a = 8'h11;
        req_data_b = 8'h22;
        req_data_c = 8'h33;
        test_reset();
        test_rotation();
        test_backpressure();
        test_idle();
        test_skip();
        test_drop();
        test_reset_discard();
`ifdef TIM_RR_SEL_ARBITER_GRANT_CNT_EN
        test_counter();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
